i2s_test_generator: RTL and testbench

//  Synthetic I2S source that stands in for the ADC in simulation and bring-up.
//  - Clocked by an externally supplied bit clock; generates LRCK and serial data.
//  - Emits a deterministic stereo test pattern: a ramp by default, optionally a sine.
//  - Feeds the top-level ADC inputs (adata, lrck), so the receive path runs without hardware.

---
 rtl/i2s_test_gen_pkg.sv | 24 ++
 rtl/i2s_sine_rom.sv | 20 ++
 rtl/i2s_test_generator.sv | 101 ++++++++++
 tb/tb_i2s_test_generator.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_test_gen_pkg.sv
// Shared constants and the sine table generator for the I2S test generator.
// The generator function is evaluated only at elaboration time to fill the ROM.
`timescale 1ns/1ps
package i2s_test_gen_pkg;
  localparam int FRAME_W = 64;
  localparam int SLOT_W  = 32;
  localparam int CNT_W   = 6;

  // Bhaskara sine approximation over 64 phases, scaled to (2^(data_w-1))-1.
  // Exact at 0, quarter and half period; stays within full scale elsewhere.
  function automatic longint sine_val(input int idx, input int data_w);
    longint amp;
    longint k;
    longint num;
    longint den;
    longint mag;
    amp = (longint'(1) << (data_w - 1)) - 1;
    k   = longint'(idx % 32);
    num = 16 * k * (32 - k);
    den = 5120 - 4 * k * (32 - k);
    mag = (amp * num + den / 2) / den;
    return ((idx % 64) >= 32) ? -mag : mag;
  endfunction
endpackage

// File: rtl/i2s_sine_rom.sv
// Combinational 64-entry sine lookup, DATA_W-bit two's complement output.
// Only instantiated when I2S_TESTGEN_SINE_EN is defined.
`timescale 1ns/1ps
module i2s_sine_rom
  import i2s_test_gen_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic [CNT_W-1:0]  i_idx,
  output logic [DATA_W-1:0] o_data
);
  logic [DATA_W-1:0] w_rom [FRAME_W];

  for (genvar g = 0; g < FRAME_W; g++) begin : g_rom
    localparam longint VAL = sine_val(g, DATA_W);
    assign w_rom[g] = VAL[DATA_W-1:0];
  end

  assign o_data = w_rom[i_idx];
endmodule

// File: rtl/i2s_test_generator.sv
// Free-running I2S source: 64-BCK frames, ramp pattern by default, sine pattern
// when I2S_TESTGEN_SINE_EN is defined. All state moves on the falling BCK edge.
`timescale 1ns/1ps
module i2s_test_generator
  import i2s_test_gen_pkg::*;
#(
  parameter int          DATA_W = 24,
  parameter int unsigned STEP   = 1
) (
  input  logic bck,
  input  logic rst_n,
  output logic lrck,
  output logic dout
);
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_lrck;
  logic                      r_dout;
  logic [DATA_W-1:0]         r_left;
  logic [DATA_W-1:0]         r_right;

  logic [CNT_W-1:0]          w_n;
  logic [$clog2(SLOT_W)-1:0] w_p;
  logic [$clog2(SLOT_W)-1:0] w_sel;
  logic                      w_frame_start;
  logic [DATA_W-1:0]         w_word;
  logic [31:0]               w_word32;
  logic                      w_bit;
  logic [DATA_W-1:0]         w_next_left;

  assign w_n           = r_cnt + CNT_W'(1);
  assign w_p           = w_n[4:0];
  assign w_frame_start = (w_n == '0);
  assign w_word        = w_n[5] ? r_right : r_left;

  // Left-justify the word so bit position p maps to index 32-p, i.e. -p mod 32.
  assign w_word32 = {w_word, {(32 - DATA_W){1'b0}}};
  assign w_sel    = 5'd0 - w_p;
  assign w_bit    = (w_p != 5'd0) && (int'(w_p) <= DATA_W) && w_word32[w_sel];

`ifdef I2S_TESTGEN_SINE_EN
  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  w_idx_next;
  logic [DATA_W-1:0] w_sine;

  assign w_idx_next  = r_idx + CNT_W'(1);
  assign w_next_left = w_sine;

  i2s_sine_rom #(
    .DATA_W (DATA_W)
  ) u_sine_rom (
    .i_idx  (w_idx_next),
    .o_data (w_sine)
  );

  always_ff @(negedge bck or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_frame_start) begin
      r_idx <= w_idx_next;
    end
  end
`else
  localparam logic [DATA_W-1:0] STEP_W = DATA_W'(STEP);

  logic [DATA_W-1:0] r_ramp;
  logic [DATA_W-1:0] w_ramp_next;

  // r_ramp always holds the value in flight, so the reset frame carries ramp 0.
  assign w_ramp_next = r_ramp + STEP_W;
  assign w_next_left = w_ramp_next;

  always_ff @(negedge bck or negedge rst_n) begin
    if (!rst_n) begin
      r_ramp <= '0;
    end else if (w_frame_start) begin
      r_ramp <= w_ramp_next;
    end
  end
`endif

  always_ff @(negedge bck or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_lrck  <= 1'b0;
      r_dout  <= 1'b0;
      r_left  <= '0;
      r_right <= '0;
    end else begin
      r_cnt  <= w_n;
      r_lrck <= w_n[5];
      r_dout <= w_bit;
      if (w_frame_start) begin
        r_left  <= w_next_left;
        r_right <= -w_next_left;
      end
    end
  end

  assign lrck = r_lrck;
  assign dout = r_dout;
endmodule

// File: tb/tb_i2s_test_generator.sv
// Bench for i2s_test_generator: decodes both channels on rising BCK and checks
// against frame arithmetic (frame f carries f*STEP on the left, its negation right).
`timescale 1ns/1ps
module tb_i2s_test_generator;
  localparam int          DATA_W = 24;
  localparam int unsigned BIG    = 32'h0080_0000;

  logic bck;
  logic rst_n;
  logic lrck1, dout1;
  logic lrck2, dout2;

  int n_tests;
  int n_fail;
  int e_cnt;
  int lrck_high_cnt;
  int first_rise_e;
  logic prev_lrck1;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp2_q[$];
  logic [DATA_W-1:0] sh1, sh2;
  logic [DATA_W-1:0] left1, left2;

  // clock / reset
  initial begin
    bck = 1'b0;
    forever #100 bck = ~bck;
  end

  // Falling edges since reset release: the frame position the DUT should be at.
  always @(negedge bck or negedge rst_n) begin
    if (!rst_n) e_cnt = 0;
    else        e_cnt = e_cnt + 1;
  end

  i2s_test_generator #(.DATA_W(DATA_W), .STEP(1)) u_dut (
    .bck   (bck),
    .rst_n (rst_n),
    .lrck  (lrck1),
    .dout  (dout1)
  );

  i2s_test_generator #(.DATA_W(DATA_W), .STEP(BIG)) u_wrap (
    .bck   (bck),
    .rst_n (rst_n),
    .lrck  (lrck2),
    .dout  (dout2)
  );

  function automatic logic [DATA_W-1:0] model_word(input int frame, input bit right,
                                                   input longint step);
    longint modv;
    longint v;
    modv = longint'(1) << DATA_W;
    v = (longint'(frame) * step) % modv;
    if (right) v = (modv - v) % modv;
    return v[DATA_W-1:0];
  endfunction

  // Receiver/scoreboard: one sample per rising BCK, for n_edges edges.
  task automatic receive(input int n_edges, input string tag);
    int e, pos, p, f;
    bit exp_l;
    logic [DATA_W-1:0] exp_w;
    for (int i = 0; i < n_edges; i++) begin
      @(posedge bck);
      e = e_cnt; pos = e % 64; p = e % 32; f = e / 64;
      exp_l = (pos >= 32);
      n_tests++;
      if (lrck1 !== exp_l) begin
        n_fail++;
        $display("FAIL %s lrck e=%0d got %b exp %b", tag, e, lrck1, exp_l);
      end
      n_tests++;
      if (lrck2 !== exp_l) begin
        n_fail++;
        $display("FAIL %s lrck_wrap e=%0d got %b exp %b", tag, e, lrck2, exp_l);
      end
      if (lrck1 === 1'b1) lrck_high_cnt++;
      if (lrck1 === 1'b1 && prev_lrck1 === 1'b0 && first_rise_e < 0) first_rise_e = e;
      prev_lrck1 = lrck1;
      if (p == 1) begin
        exp_q.push_back(model_word(f, exp_l, 1));
        exp2_q.push_back(model_word(f, exp_l, BIG));
        sh1 = '0;
        sh2 = '0;
      end
      if (p >= 1 && p <= DATA_W) begin
        sh1 = {sh1[DATA_W-2:0], dout1};
        sh2 = {sh2[DATA_W-2:0], dout2};
        if (p == DATA_W) begin
`ifdef I2S_TESTGEN_SINE_EN
          void'(exp_q.pop_front());
          void'(exp2_q.pop_front());
          if (!exp_l) begin
            left1 = sh1; left2 = sh2;
            if (f % 64 == 0) begin
              n_tests++;
              if (sh1 !== '0) begin
                n_fail++;
                $display("FAIL %s sine_zero f=%0d got %h exp %h", tag, f, sh1, 24'h0);
              end
            end
            if (f % 64 == 16) begin
              n_tests++;
              if (sh1 !== 24'h7FFFFF) begin
                n_fail++;
                $display("FAIL %s sine_peak f=%0d got %h exp %h", tag, f, sh1, 24'h7FFFFF);
              end
            end
          end else begin
            n_tests++;
            if (sh1 !== -left1) begin
              n_fail++;
              $display("FAIL %s sine_right f=%0d got %h exp %h", tag, f, sh1, -left1);
            end
            n_tests++;
            if (sh2 !== -left2) begin
              n_fail++;
              $display("FAIL %s sine_right_wrap f=%0d got %h exp %h", tag, f, sh2, -left2);
            end
          end
`else
          exp_w = exp_q.pop_front();
          n_tests++;
          if (sh1 !== exp_w) begin
            n_fail++;
            $display("FAIL %s word f=%0d ch=%0d got %h exp %h", tag, f, exp_l, sh1, exp_w);
          end
          exp_w = exp2_q.pop_front();
          n_tests++;
          if (sh2 !== exp_w) begin
            n_fail++;
            $display("FAIL %s word_wrap f=%0d ch=%0d got %h exp %h", tag, f, exp_l, sh2, exp_w);
          end
`endif
        end
      end else begin
        n_tests++;
        if (dout1 !== 1'b0 || dout2 !== 1'b0) begin
          n_fail++;
          $display("FAIL %s pad e=%0d got %b%b exp 00", tag, e, dout1, dout2);
        end
      end
    end
  endtask

  task automatic check_idle(input string tag);
    n_tests++;
    if (lrck1 !== 1'b0 || dout1 !== 1'b0 || lrck2 !== 1'b0 || dout2 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle got %b%b%b%b exp 0000", tag, lrck1, dout1, lrck2, dout2);
    end
  endtask

  // Hold reset for a few cycles, release between edges, check the first falling edge.
  task automatic release_reset(input int hold_cycles, input string tag);
    repeat (hold_cycles) begin
      @(posedge bck);
      check_idle({tag, "_hold"});
    end
    @(posedge bck);
    #50 rst_n = 1'b1;
    #10 check_idle({tag, "_release"});
    @(negedge bck);
    #1;
    n_tests++;
    if (dout1 !== 1'b0 || lrck1 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s first_fall got %b%b exp 00", tag, lrck1, dout1);
    end
  endtask

  task automatic test_reset();
    release_reset(4, "reset");
  endtask

  task automatic test_framing();
    lrck_high_cnt = 0;
    first_rise_e  = -1;
    prev_lrck1    = 1'b0;
    receive(64, "framing");
    n_tests++;
    if (lrck_high_cnt != 32) begin
      n_fail++;
      $display("FAIL framing duty got %0d exp %0d", lrck_high_cnt, 32);
    end
    n_tests++;
    if (first_rise_e != 32) begin
      n_fail++;
      $display("FAIL framing first_rise got %0d exp %0d", first_rise_e, 32);
    end
  endtask

  task automatic test_delay();
    receive(64, "delay");
  endtask

  task automatic test_wrap();
    receive(128, "wrap");
  endtask

  task automatic test_random_run();
    receive(64 * $urandom_range(2, 5), "random");
  endtask

  task automatic mid_reset(input int at_pos, input string tag);
    int guard;
    guard = 0;
    while ((e_cnt % 64) != at_pos || e_cnt < 64) begin
      receive(1, tag);
      guard++;
      if (guard > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s timeout got %0d exp %0d", tag, e_cnt, at_pos);
        break;
      end
    end
    #20 rst_n = 1'b0;
    #1 check_idle({tag, "_immediate"});
    exp_q.delete();
    exp2_q.delete();
    release_reset($urandom_range(1, 4), tag);
    receive(3 * 64, {tag, "_restart"});
  endtask

  task automatic test_mid_reset();
    mid_reset(40, "mid_reset");
  endtask

  task automatic test_random_reset();
    mid_reset($urandom_range(1, 63), "rand_reset");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    sh1 = '0; sh2 = '0; left1 = '0; left2 = '0;
    prev_lrck1 = 1'b0;
    lrck_high_cnt = 0;
    first_rise_e = -1;
    test_reset();
    test_framing();
    test_delay();
    test_wrap();
    test_random_run();
    test_mid_reset();
    test_random_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
